// File: rtl/dual_port_ram.sv
// True dual-port RAM with synchronous writes and combinational reads.
// Both ports share one storage array. On a same-address collision, port 2 wins.
module dual_port_ram #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int ADDR_WIDTH    = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [IN_DATA_WIDTH-1:0] Data_1,
    input  logic [ADDR_WIDTH-1:0]    Address_1,
    input  logic                     WE_1,
    output logic [IN_DATA_WIDTH-1:0] Output_1,
    input  logic [IN_DATA_WIDTH-1:0] Data_2,
    input  logic [ADDR_WIDTH-1:0]    Address_2,
    input  logic                     WE_2,
    output logic [IN_DATA_WIDTH-1:0] Output_2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [IN_DATA_WIDTH-1:0] mem [DEPTH];

    // The port 2 write is issued after the port 1 write, so it overrides port 1 on a collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem <= '{default: '0};
        end else begin
            if (WE_1) begin
                mem[Address_1] <= Data_1;
            end
            if (WE_2) begin
                mem[Address_2] <= Data_2;
            end
        end
    end

    assign Output_1 = mem[Address_1];
    assign Output_2 = mem[Address_2];

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
// Inputs change 1 time unit after each rising edge. Outputs are sampled before the next edge.
`timescale 1ns/1ps
module tb_dual_port_ram;

    logic       CLK_TB;
    logic       rst;
    logic [7:0] data_1, data_2;
    logic [5:0] address_1, address_2;
    logic       we_1, we_2;
    logic [7:0] output_1, output_2;

    int checks = 0;
    int errors = 0;

    dual_port_ram #(.IN_DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .CLK      (CLK_TB),
        .RST      (rst),
        .Data_1   (data_1),
        .Address_1(address_1),
        .WE_1     (we_1),
        .Output_1 (output_1),
        .Data_2   (data_2),
        .Address_2(address_2),
        .WE_2     (we_2),
        .Output_2 (output_2)
    );

    initial CLK_TB = 1'b0;
    always #5 CLK_TB = ~CLK_TB;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_TB);
        #1;
    endtask

    initial begin
        rst = 1'b1; we_1 = 1'b0; we_2 = 1'b0;
        data_1 = 8'h00; data_2 = 8'h00; address_1 = 6'd0; address_2 = 6'd0;
        tick();
        rst = 1'b0;

        // Every word reads zero after reset.
        address_1 = 6'd0;  address_2 = 6'd0;  #1;
        check_val("rst_p1_a0", output_1, 8'h00);
        check_val("rst_p2_a0", output_2, 8'h00);
        address_1 = 6'd1;  address_2 = 6'd1;  #1;
        check_val("rst_p1_a1", output_1, 8'h00);
        check_val("rst_p2_a1", output_2, 8'h00);
        address_1 = 6'd63; address_2 = 6'd63; #1;
        check_val("rst_p1_a63", output_1, 8'h00);
        check_val("rst_p2_a63", output_2, 8'h00);

        // Port 1 write.
        address_1 = 6'd0; data_1 = 8'hB5; we_1 = 1'b1;
        #1;
        check_val("pre_edge_a0", output_1, 8'h00);
        tick();
        we_1 = 1'b0; #1;
        check_val("p1_wr_a0", output_1, 8'hB5);

        // Port 2 write. Address 0 must keep its value.
        address_2 = 6'd1; data_2 = 8'hD4; we_2 = 1'b1;
        tick();
        we_2 = 1'b0; #1;
        check_val("p2_wr_a1", output_2, 8'hD4);
        address_1 = 6'd0; #1;
        check_val("a0_kept", output_1, 8'hB5);

        // Cross-port read right after the write edge.
        address_1 = 6'd2; data_1 = 8'hA3; we_1 = 1'b1; address_2 = 6'd0;
        tick();
        we_1 = 1'b0;
        address_2 = 6'd2; #1;
        check_val("xport_a2", output_2, 8'hA3);
        check_val("same_port_a2", output_1, 8'hA3);

        // No write when WE is low.
        data_1 = 8'h3C; data_2 = 8'hC3;
        tick();
        check_val("no_we_p1", output_1, 8'hA3);
        check_val("no_we_p2", output_2, 8'hA3);

        // Collision: port 2 wins.
        address_1 = 6'd5; address_2 = 6'd5; data_1 = 8'h11; data_2 = 8'h22;
        we_1 = 1'b1; we_2 = 1'b1;
        tick();
        we_1 = 1'b0; we_2 = 1'b0; #1;
        check_val("coll_p1", output_1, 8'h22);
        check_val("coll_p2", output_2, 8'h22);

        // Simultaneous writes to different addresses.
        address_1 = 6'd6; address_2 = 6'd7; we_1 = 1'b1; we_2 = 1'b1;
        tick();
        we_1 = 1'b0; we_2 = 1'b0;
        address_1 = 6'd7; address_2 = 6'd6; #1;
        check_val("dual_a7", output_1, 8'h22);
        check_val("dual_a6", output_2, 8'h11);

        // Write to the top address, then reset with a write pending on that edge.
        address_1 = 6'd63; data_1 = 8'hFF; we_1 = 1'b1;
        tick();
        we_1 = 1'b0; #1;
        check_val("wr_a63", output_1, 8'hFF);
        rst = 1'b1; we_1 = 1'b1; data_1 = 8'h5A;
        tick();
        rst = 1'b0; we_1 = 1'b0; #1;
        check_val("rst_drop_a63", output_1, 8'h00);
        address_2 = 6'd0; #1;
        check_val("rst_clr_a0", output_2, 8'h00);
        address_2 = 6'd5; #1;
        check_val("rst_clr_a5", output_2, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
